enum_index_pipe: RTL and testbench
==================================

// Module: enum_index_pipe
// PURPOSE
//  Parametrised, pipelined successor to the single-stage enum-offset array index.
//  Each accepted transaction carries a selector and a flattened array of N entries.
//  The block computes idx = sel + OFFSET and returns arr[idx] after STAGES registered stages.
//  It adds a valid/ready handshake with backpressure, a selectable out-of-bounds policy,
//  and a saturating OOB event counter.
// PARAMETERS
//  W        32  entry width, bits
//  N        4   number of array entries, >=1
//  SEL_W    2   selector width; OFFSET < 2**SEL_W
//  OFFSET   1   constant added to sel before indexing
//  STAGES   2   pipeline depth, >=1; also the latency in cycles
//  OOB_MODE 0   0 = clamp to arr[N-1]; 1 = return zero and set out_oob
//  CNT_W    8   width of oob_count
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      sel/arr valid
//  in_ready   out  1      block can accept this cycle
//  sel        in   SEL_W  enum selector
//  arr        in   N*W    flattened array; entry k = arr[k*W +: W]
//  out_valid  out  1      out/out_oob valid
//  out_ready  in   1      downstream accepts
//  out        out  W      selected entry
//  out_oob    out  1      index was >= N (meaningful in both modes)
//  clr_count  in   1      synchronous clear of oob_count
//  oob_count  out  CNT_W  saturating count of accepted OOB transactions
// BEHAVIOUR
//  Reset (async, rst=1):
//   - all stage valid bits, out_valid, out, out_oob and oob_count go to 0
//   - in_ready = 1 once the pipeline is empty after reset
//  Index arithmetic:
//   - idx = {1'b0,sel} + OFFSET, computed in SEL_W+1 bits; this cannot wrap
//   - oob = (idx >= N)
//   - OOB_MODE 0: data = arr[N-1]; OOB_MODE 1: data = 0. out_oob = oob in both modes.
//   - Select is done in stage 0 from the live arr/sel; only W+1 bits travel further.
//  Pipeline:
//   - advance = !out_valid || out_ready; in_ready = advance (combinational)
//   - accept = in_valid && in_ready
//   - on advance, every stage shifts by one; stage 0 loads {accept, data, oob}
//   - no stage updates while advance=0 (global stall); all data held stable
//   - stalled output keeps out/out_oob stable while out_valid=1 && !out_ready
//   - latency STAGES cycles from accept to out_valid with no stalls
//   - throughput 1 transaction/cycle; order preserved; no drops, no duplicates
//   - bubbles are not collapsed: an empty stage still takes a cycle to pass
//   - in_valid without in_ready: nothing captured; sender must hold
//  Counter:
//   - increments by 1 on each accept with oob=1
//   - saturates at 2**CNT_W-1
//   - clr_count has priority: count=0 that cycle, and a coincident OOB accept is not counted
// TESTING
//  1. N=4,OFFSET=1,sel=0..2, arr={40,30,20,10} (entry0=10) -> out 20,30,40 at cycles 2,3,4 after accept; out_oob=0
//  2. OOB_MODE=0, sel=3 -> out=40, out_oob=1, oob_count 0->1; with OOB_MODE=1 -> out=0, out_oob=1
//  3. Stream 6 back-to-back txns with out_ready low for cycles 3-5 -> in_ready low in those cycles;
//     all 6 emerge in order; out held stable during the stall
//  4. 300 OOB accepts with CNT_W=8 -> oob_count sticks at 255; clr_count together with an OOB accept -> count=0
//  5. Assert rst mid-stream with 2 stages valid -> out_valid=0, oob_count=0 immediately;
//     first post-reset txn appears after STAGES cycles
//  6. STAGES=1, N=3, SEL_W=2, OFFSET=0, sel=3 -> out_oob=1 one cycle after accept; sel=2 -> arr[2], oob=0

Source files
------------

// File: rtl/enum_index_pipe_if.sv
// ---------------------------------------------------------------------------
// enum_index_pipe_if
//   Bundles the handshake, payload and counter signals of enum_index_pipe.
//   slave  : the index pipe itself (consumes sel/arr, produces out/out_oob)
//   master : the agent that feeds transactions and drains results
//
//   in_valid  / in_ready   : upstream handshake
//   sel, arr              : selector and flattened array (entry k = arr[k*W +: W])
//   out_valid / out_ready  : downstream handshake
//   out, out_oob          : selected entry and out-of-bounds flag
//   clr_count, oob_count  : synchronous clear and saturating OOB event count
// ---------------------------------------------------------------------------
interface enum_index_pipe_if #(
   parameter int W     = 32,
   parameter int N     = 4,
   parameter int SEL_W = 2,
   parameter int CNT_W = 8
) ();

   logic             in_valid;
   logic             in_ready;
   logic [SEL_W-1:0] sel;
   logic [N*W-1:0]   arr;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out;
   logic             out_oob;
   logic             clr_count;
   logic [CNT_W-1:0] oob_count;

   modport slave (
      input  in_valid,
      output in_ready,
      input  sel,
      input  arr,
      output out_valid,
      input  out_ready,
      output out,
      output out_oob,
      input  clr_count,
      output oob_count
   );

   modport master (
      output in_valid,
      input  in_ready,
      output sel,
      output arr,
      input  out_valid,
      output out_ready,
      input  out,
      input  out_oob,
      output clr_count,
      input  oob_count
   );

endinterface

// File: rtl/enum_index_pipe.sv
// ---------------------------------------------------------------------------
// enum_index_pipe
//   Pipelined enum-offset array index. Each accepted transaction carries a
//   selector and a flattened array of N entries; the block computes
//   idx = sel + OFFSET and returns arr[idx] after STAGES register stages.
//   Out-of-range indices either clamp to the last entry (OOB_MODE 0) or
//   return zero (OOB_MODE 1); out_oob flags them in both modes, and a
//   saturating counter tallies accepted out-of-range transactions.
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : enum_index_pipe_if.slave
//            in_valid/in_ready, sel, arr   - input handshake and payload
//            out_valid/out_ready, out,     - output handshake and result
//            out_oob
//            clr_count, oob_count          - OOB counter clear / value
//
// The whole pipeline advances together: a stalled output freezes every
// stage, so in_ready is simply "the output register can move".
// ---------------------------------------------------------------------------
module enum_index_pipe #(
   parameter int W        = 32,
   parameter int N        = 4,
   parameter int SEL_W    = 2,
   parameter int OFFSET   = 1,
   parameter int STAGES   = 2,
   parameter int OOB_MODE = 0,
   parameter int CNT_W    = 8
) (
   input  logic               clk,
   input  logic               rst,
   enum_index_pipe_if.slave   bus
);

   // One extra bit so sel + OFFSET never wraps.
   localparam int IDX_W = SEL_W + 1;

   // ------------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------------

   // Saturating +1 for the OOB event counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == {CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + CNT_W'(1);
      end
      return r;
   endfunction

   // Out-of-range test done at 32 bits so N may exceed the index range.
   function automatic logic idx_is_oob(input logic [IDX_W-1:0] idx);
      return (32'(idx) >= 32'(N));
   endfunction

   // Entry selection including the out-of-range policy.
   function automatic logic [W-1:0] pick_entry(
      input logic [N*W-1:0]   a,
      input logic [IDX_W-1:0] idx,
      input logic             oob
   );
      logic [W-1:0] r;
      r = '0;
      if (oob) begin
         if (OOB_MODE == 0) begin
            r = a[(N-1)*W +: W];
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            if (32'(idx) == 32'(k)) begin
               r = a[k*W +: W];
            end
         end
      end
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Control signals
   // ------------------------------------------------------------------------
   logic              advance;
   logic              accept;
   logic [STAGES-1:0] vld_p;
   logic [CNT_W-1:0]  oob_count_q;

   assign advance = !vld_p[STAGES-1] || bus.out_ready;
   assign accept  = bus.in_valid && advance;

   // ------------------------------------------------------------------------
   // Stage 0 (combinational): index arithmetic and select on live inputs.
   // Only W+1 bits (entry + oob flag) travel down the pipeline.
   // ------------------------------------------------------------------------
   logic [IDX_W-1:0] idx_p0;
   logic             oob_p0;
   logic [W-1:0]     data_p0;

   always_comb begin
      idx_p0  = {1'b0, bus.sel} + IDX_W'(OFFSET);
      oob_p0  = idx_is_oob(idx_p0);
      data_p0 = pick_entry(bus.arr, idx_p0, oob_p0);
   end

   // ------------------------------------------------------------------------
   // Stages 0..STAGES-1: valid bits (reset) and payload (no reset).
   // Every stage shifts on advance; nothing moves during a stall.
   // ------------------------------------------------------------------------
   logic [W-1:0]      data_p [STAGES];
   logic [STAGES-1:0] oob_p;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p <= '0;
      end else if (advance) begin
         vld_p[0] <= accept;
         for (int i = 1; i < STAGES; i++) begin
            vld_p[i] <= vld_p[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         data_p[0] <= data_p0;
         oob_p[0]  <= oob_p0;
         for (int i = 1; i < STAGES; i++) begin
            data_p[i] <= data_p[i-1];
            oob_p[i]  <= oob_p[i-1];
         end
      end
   end

   // ------------------------------------------------------------------------
   // OOB event counter: clear wins over a coincident OOB accept.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oob_count_q <= '0;
      end else if (bus.clr_count) begin
         oob_count_q <= '0;
      end else if (accept && oob_p0) begin
         oob_count_q <= sat_inc(oob_count_q);
      end
   end

   // ------------------------------------------------------------------------
   // Output stage: payload is gated by valid so the visible out/out_oob are
   // zero whenever nothing valid sits in the last stage (including reset),
   // without needing a reset on the data registers.
   // ------------------------------------------------------------------------
   assign bus.in_ready  = advance;
   assign bus.out_valid = vld_p[STAGES-1];
   assign bus.out       = vld_p[STAGES-1] ? data_p[STAGES-1] : '0;
   assign bus.out_oob   = vld_p[STAGES-1] & oob_p[STAGES-1];
   assign bus.oob_count = oob_count_q;

endmodule

// File: tb/tb_enum_index_pipe.sv
// ---------------------------------------------------------------------------
// tb_enum_index_pipe
//   Bench for enum_index_pipe. dut_a (clamp) and dut_b (zero) share one
//   stimulus stream and are checked every cycle against a transaction-level
//   model; dut_c (STAGES=1, N=3, OFFSET=0) gets a short directed sequence.
// ---------------------------------------------------------------------------
module tb_enum_index_pipe;

   localparam int STAGES = 2;

   logic clk;
   logic rst;

   // Shared stimulus for dut_a / dut_b
   logic         in_valid;
   logic [1:0]   sel;
   logic [127:0] arr;
   logic         out_ready;
   logic         clr_count;

   // Stimulus for dut_c
   logic         c_in_valid;
   logic [1:0]   c_sel;
   logic [95:0]  c_arr;
   logic         c_out_ready;
   logic         c_clr_count;

   int n_chk  = 0;
   int n_fail = 0;

   enum_index_pipe_if #(.W(32), .N(4), .SEL_W(2), .CNT_W(8)) ifa ();
   enum_index_pipe_if #(.W(32), .N(4), .SEL_W(2), .CNT_W(8)) ifb ();
   enum_index_pipe_if #(.W(32), .N(3), .SEL_W(2), .CNT_W(8)) ifc ();

   assign ifa.in_valid  = in_valid;
   assign ifa.sel       = sel;
   assign ifa.arr       = arr;
   assign ifa.out_ready = out_ready;
   assign ifa.clr_count = clr_count;

   assign ifb.in_valid  = in_valid;
   assign ifb.sel       = sel;
   assign ifb.arr       = arr;
   assign ifb.out_ready = out_ready;
   assign ifb.clr_count = clr_count;

   assign ifc.in_valid  = c_in_valid;
   assign ifc.sel       = c_sel;
   assign ifc.arr       = c_arr;
   assign ifc.out_ready = c_out_ready;
   assign ifc.clr_count = c_clr_count;

   enum_index_pipe #(.W(32), .N(4), .SEL_W(2), .OFFSET(1), .STAGES(2),
                     .OOB_MODE(0), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
   enum_index_pipe #(.W(32), .N(4), .SEL_W(2), .OFFSET(1), .STAGES(2),
                     .OOB_MODE(1), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
   enum_index_pipe #(.W(32), .N(3), .SEL_W(2), .OFFSET(0), .STAGES(1),
                     .OOB_MODE(0), .CNT_W(8)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level reference: idx = sel+1 over 4 entries.
   function automatic void model(input logic [1:0] s, input logic [127:0] a,
                                 output logic [31:0] ea, output logic [31:0] eb,
                                 output logic o);
      int idx;
      idx = int'(s) + 1;
      o   = (idx >= 4);
      if (o) begin
         ea = a[127:96];
         eb = 32'd0;
      end else begin
         ea = a[idx*32 +: 32];
         eb = ea;
      end
   endfunction

   function automatic logic [127:0] mk_arr(input int t);
      logic [127:0] r;
      for (int j = 0; j < 4; j++) r[j*32 +: 32] = 32'(100*t + j);
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Scoreboard and per-cycle compare (sampled on the falling edge)
   // ------------------------------------------------------------------------
   typedef struct {
      logic [31:0] ea;
      logic [31:0] eb;
      logic        o;
      int          adv_at;
   } exp_t;

   exp_t        q[$];
   bit          front_seen = 0;
   int          adv_cnt    = 0;
   logic [7:0]  cnt_m      = 8'd0;
   bit          prev_stall = 0;
   logic [31:0] hold_a, hold_b;
   logic        hold_o;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         q.delete();
         front_seen = 0;
         cnt_m      = 8'd0;
         prev_stall = 0;
         chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
         chk("rst_count",     64'(ifa.oob_count), 64'd0);
      end else begin
         chk("count_a",  64'(ifa.oob_count), 64'(cnt_m));
         chk("count_b",  64'(ifb.oob_count), 64'(cnt_m));
         chk("in_ready", 64'(ifa.in_ready),  64'(!ifa.out_valid || out_ready));
         chk("valid_ab", 64'(ifb.out_valid), 64'(ifa.out_valid));
         if (prev_stall) begin
            chk("stall_valid", 64'(ifa.out_valid), 64'd1);
            chk("stall_out_a", 64'(ifa.out),       64'(hold_a));
            chk("stall_out_b", 64'(ifb.out),       64'(hold_b));
            chk("stall_oob",   64'(ifa.out_oob),   64'(hold_o));
         end
         if (ifa.out_valid) begin
            chk("queue_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
               if (!front_seen) begin
                  chk("latency", 64'(adv_cnt - q[0].adv_at), 64'(STAGES));
                  front_seen = 1;
               end
               chk("out_a", 64'(ifa.out),     64'(q[0].ea));
               chk("oob_a", 64'(ifa.out_oob), 64'(q[0].o));
               chk("out_b", 64'(ifb.out),     64'(q[0].eb));
               chk("oob_b", 64'(ifb.out_oob), 64'(q[0].o));
               if (out_ready) begin
                  void'(q.pop_front());
                  front_seen = 0;
               end
            end
         end
         prev_stall = ifa.out_valid && !out_ready;
         hold_a     = ifa.out;
         hold_b     = ifb.out;
         hold_o     = ifa.out_oob;
         if (in_valid && ifa.in_ready) begin
            model(sel, arr, e.ea, e.eb, e.o);
            e.adv_at = adv_cnt;
            q.push_back(e);
         end
         if (!ifa.out_valid || out_ready) adv_cnt++;
         if (clr_count) cnt_m = 8'd0;
         else if (in_valid && ifa.in_ready && sel == 2'd3 && cnt_m != 8'd255) cnt_m = cnt_m + 8'd1;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------------
   // Directed stimulus
   // ------------------------------------------------------------------------
   initial begin
      int t;
      int c;
      bit acc;
      logic [1:0] sels [6];
      sels = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd0};

      rst = 1'b1;
      in_valid = 1'b0; sel = 2'd0; arr = '0; out_ready = 1'b1; clr_count = 1'b0;
      c_in_valid = 1'b0; c_sel = 2'd0; c_arr = '0; c_out_ready = 1'b1; c_clr_count = 1'b0;
      tick();
      tick();
      // reset state
      chk("reset_out_valid", 64'(ifa.out_valid), 64'd0);
      chk("reset_out",       64'(ifa.out),       64'd0);
      chk("reset_out_oob",   64'(ifa.out_oob),   64'd0);
      chk("reset_count",     64'(ifa.oob_count), 64'd0);
      chk("reset_in_ready",  64'(ifa.in_ready),  64'd1);
      rst = 1'b0;
      tick();

      // 1: sel 0..2 with arr {40,30,20,10}
      arr = {32'd40, 32'd30, 32'd20, 32'd10};
      in_valid = 1'b1; sel = 2'd0;
      tick();
      chk("t1_lat_not_yet", 64'(ifa.out_valid), 64'd0);
      sel = 2'd1;
      tick();
      chk("t1_valid0", 64'(ifa.out_valid), 64'd1);
      chk("t1_out0",   64'(ifa.out),       64'd20);
      sel = 2'd2;
      tick();
      chk("t1_out1",   64'(ifa.out),       64'd30);
      in_valid = 1'b0;
      tick();
      chk("t1_out2",   64'(ifa.out),       64'd40);
      chk("t1_oob2",   64'(ifa.out_oob),   64'd0);
      tick();
      chk("t1_drained", 64'(ifa.out_valid), 64'd0);

      // 2: sel 3 is out of range
      in_valid = 1'b1; sel = 2'd3;
      tick();
      in_valid = 1'b0;
      chk("t2_count_a", 64'(ifa.oob_count), 64'd1);
      chk("t2_count_b", 64'(ifb.oob_count), 64'd1);
      tick();
      chk("t2_out_clamp", 64'(ifa.out),     64'd40);
      chk("t2_oob_a",     64'(ifa.out_oob), 64'd1);
      chk("t2_out_zero",  64'(ifb.out),     64'd0);
      chk("t2_oob_b",     64'(ifb.out_oob), 64'd1);
      tick();
      tick();

      // 3: six back-to-back with downstream stall in cycles 3..5
      t = 0;
      c = 0;
      while (t < 6 && c < 40) begin
         out_ready = !(c >= 3 && c <= 5);
         in_valid  = 1'b1;
         sel       = sels[t];
         arr       = mk_arr(t);
         @(negedge clk);
         if (c >= 3 && c <= 5) begin
            chk("t3_in_ready_low", 64'(ifa.in_ready), 64'd0);
            chk("t3_held_out",     64'(ifa.out),      64'd102);
         end
         acc = ifa.in_ready;
         @(posedge clk);
         #1;
         if (acc) t++;
         c++;
      end
      chk("t3_all_accepted", 64'(t), 64'd6);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) tick();
      chk("t3_drained", 64'(q.size()), 64'd0);

      // 4: counter saturation and clear priority
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      chk("t4_cleared", 64'(ifa.oob_count), 64'd0);
      arr = {32'd40, 32'd30, 32'd20, 32'd10};
      in_valid = 1'b1; sel = 2'd3;
      repeat (100) tick();
      chk("t4_count100", 64'(ifa.oob_count), 64'd100);
      repeat (200) tick();
      chk("t4_sat_a", 64'(ifa.oob_count), 64'd255);
      chk("t4_sat_b", 64'(ifb.oob_count), 64'd255);
      clr_count = 1'b1;
      tick();
      clr_count = 1'b0;
      in_valid  = 1'b0;
      chk("t4_clr_wins", 64'(ifa.oob_count), 64'd0);
      repeat (3) tick();

      // 5: async reset with two stages occupied
      in_valid = 1'b1; sel = 2'd3;
      tick();
      tick();
      in_valid = 1'b0;
      chk("t5_pre_valid", 64'(ifa.out_valid), 64'd1);
      #1 rst = 1'b1;
      #1;
      chk("t5_rst_valid", 64'(ifa.out_valid), 64'd0);
      chk("t5_rst_count", 64'(ifa.oob_count), 64'd0);
      chk("t5_rst_out",   64'(ifa.out),       64'd0);
      tick();
      rst = 1'b0;
      in_valid = 1'b1; sel = 2'd0;
      tick();
      in_valid = 1'b0;
      chk("t5_post_lat", 64'(ifa.out_valid), 64'd0);
      tick();
      chk("t5_post_valid", 64'(ifa.out_valid), 64'd1);
      chk("t5_post_out",   64'(ifa.out),       64'd20);
      repeat (3) tick();

      // 6: STAGES=1, N=3, OFFSET=0
      c_arr = {32'd9, 32'd8, 32'd7};
      c_in_valid = 1'b1; c_sel = 2'd3;
      chk("t6_idle", 64'(ifc.out_valid), 64'd0);
      tick();
      chk("t6_valid",  64'(ifc.out_valid), 64'd1);
      chk("t6_oob",    64'(ifc.out_oob),   64'd1);
      chk("t6_clamp",  64'(ifc.out),       64'd9);
      chk("t6_count",  64'(ifc.oob_count), 64'd1);
      c_sel = 2'd2;
      tick();
      chk("t6_out2",   64'(ifc.out),       64'd9);
      chk("t6_oob2",   64'(ifc.out_oob),   64'd0);
      c_sel = 2'd1;
      tick();
      chk("t6_out1",   64'(ifc.out),       64'd8);
      c_in_valid = 1'b0;
      tick();
      chk("t6_empty",  64'(ifc.out_valid), 64'd0);
      chk("t6_count_end", 64'(ifc.oob_count), 64'd1);

      repeat (3) tick();
      chk("final_queue_empty", 64'(q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
